// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: default widths and
// the requester indices used for the request/grant vectors.
package regfile_wb_arbiter_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;
   localparam int REQ_ALU    = 0;
   localparam int REQ_LSU    = 1;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: ALU/LSU requests, issue-stage claim/lookup, and the
// register_memory write port.
interface regfile_wb_arbiter_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   localparam int NUM_REGS = 1 << REG_ADDR_W;

   logic                  alu_valid, alu_ready;
   logic [REG_ADDR_W-1:0] alu_rd;
   logic [XLEN-1:0]       alu_data;
   logic                  lsu_valid, lsu_ready;
   logic [REG_ADDR_W-1:0] lsu_rd;
   logic [XLEN-1:0]       lsu_data;
   logic                  claim_valid;
   logic [REG_ADDR_W-1:0] claim_rd, rs1, rs2;
   logic                  stall;
   logic [NUM_REGS-1:0]   pending;
   logic                  wr_enable;
   logic [REG_ADDR_W-1:0] wr_address;
   logic [XLEN-1:0]       wr_data;

   modport slave (
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             claim_valid, claim_rd, rs1, rs2,
      output alu_ready, lsu_ready, stall, pending, wr_enable, wr_address, wr_data
   );
   modport master (
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             claim_valid, claim_rd, rs1, rs2,
      input  alu_ready, lsu_ready, stall, pending, wr_enable, wr_address, wr_data
   );
endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-way writeback grant: round-robin on ties, or LSU-first when
// FIXED_PRIORITY is set. Grants are suppressed while reset is high.
module wb_rr_arbiter2
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int FIXED_PRIORITY = 0
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);
   // Reset value 0 means "ALU granted last", so the LSU wins the first tie.
   logic last_lsu_q, last_lsu_d;

   always_comb begin
      gnt_o = '0;
      if (!reset) begin
         if (req_i[REQ_ALU] && req_i[REQ_LSU]) begin
            if (FIXED_PRIORITY != 0 || !last_lsu_q) gnt_o[REQ_LSU] = 1'b1;
            else                                     gnt_o[REQ_ALU] = 1'b1;
         end else begin
            gnt_o = req_i;
         end
      end
   end

   always_comb begin
      last_lsu_d = last_lsu_q;
      if (gnt_o[REQ_LSU])      last_lsu_d = 1'b1;
      else if (gnt_o[REQ_ALU]) last_lsu_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) last_lsu_q <= 1'b0;
      else       last_lsu_q <= last_lsu_d;
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register_memory write port between ALU and LSU writeback and keeps
// the pending-write scoreboard the issue stage uses for RAW stalls.
module regfile_wb_arbiter #(
   parameter int XLEN           = regfile_wb_arbiter_pkg::XLEN,
   parameter int REG_ADDR_W     = regfile_wb_arbiter_pkg::REG_ADDR_W,
   parameter int FIXED_PRIORITY = 0
)(
   input  logic                 clk,
   input  logic                 reset,
   regfile_wb_arbiter_if.slave  bus
);
   import regfile_wb_arbiter_pkg::*;

   localparam int NREGS = 1 << REG_ADDR_W;

   logic [1:0]            req, gnt;
   logic                  grant;
   logic [REG_ADDR_W-1:0] g_rd;
   logic [XLEN-1:0]       g_data;
   logic [NREGS-1:0]      pending_q, pending_d;
   logic                  wr_en_q;
   logic [REG_ADDR_W-1:0] wr_addr_q;
   logic [XLEN-1:0]       wr_data_q;

   always_comb begin
      req          = '0;
      req[REQ_ALU] = bus.alu_valid;
      req[REQ_LSU] = bus.lsu_valid;
   end

   wb_rr_arbiter2 #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req_i (req),
      .gnt_o (gnt)
   );

   assign grant  = |gnt;
   assign g_rd   = gnt[REQ_LSU] ? bus.lsu_rd   : bus.alu_rd;
   assign g_data = gnt[REQ_LSU] ? bus.lsu_data : bus.alu_data;

   // Clear first, then set: a claim in the same cycle as the retiring write
   // belongs to a newly issued producer and must survive.
   always_comb begin
      pending_d = pending_q;
      if (grant)           pending_d[g_rd]         = 1'b0;
      if (bus.claim_valid) pending_d[bus.claim_rd] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
         if (grant) begin
            wr_en_q   <= (g_rd != '0);
            wr_addr_q <= g_rd;
            wr_data_q <= g_data;
         end else begin
            wr_en_q   <= 1'b0;
         end
      end
   end

   assign bus.alu_ready  = gnt[REQ_ALU];
   assign bus.lsu_ready  = gnt[REQ_LSU];
   assign bus.stall      = pending_q[bus.rs1] | pending_q[bus.rs2];
   assign bus.pending    = pending_q;
   assign bus.wr_enable  = wr_en_q;
   assign bus.wr_address = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_regfile_wb_arbiter;
   localparam int TB_FP = 0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter #(.XLEN(32), .REG_ADDR_W(5), .FIXED_PRIORITY(TB_FP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // register_memory stand-in: captures on the falling edge, x0 reads 0
   logic [31:0] rmem [32] = '{default: 32'h0};
   always @(negedge clk) if (bus.wr_enable) rmem[bus.wr_address] <= bus.wr_data;
   function automatic logic [31:0] rd_mem(input int a);
      return (a == 0) ? 32'h0 : rmem[a];
   endfunction

   int n_tests = 0, n_fail = 0;

   // behavioural model
   bit          m_pend [32];
   logic [31:0] m_rf [32];
   bit          m_lsu_tie = 1'b1;
   bit          m_wen = 1'b0;
   logic [4:0]  m_waddr = '0;
   logic [31:0] m_wdata = '0;
   bit          s_alu_rdy, s_lsu_rdy, s_stall, s_was_rst;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_pend_vec();
      logic [31:0] v = '0;
      for (int i = 0; i < 32; i++) v[i] = m_pend[i];
      return v;
   endfunction

   // Called at posedge+1 with inputs set; returns at the next posedge+1.
   task automatic step();
      bit ga, gl;
      logic [4:0]  rd;
      logic [31:0] dt;
      #2;
      ga = 0; gl = 0;
      if (!reset) begin
         if (bus.alu_valid && bus.lsu_valid) begin
            if (TB_FP != 0 || m_lsu_tie) gl = 1; else ga = 1;
         end else begin
            ga = bus.alu_valid; gl = bus.lsu_valid;
         end
      end
      s_alu_rdy = bus.alu_ready;
      s_lsu_rdy = bus.lsu_ready;
      s_stall   = bus.stall;
      chk("alu_ready", bus.alu_ready, ga);
      chk("lsu_ready", bus.lsu_ready, gl);
      chk("stall", bus.stall, m_pend[bus.rs1] | m_pend[bus.rs2]);
      @(posedge clk);
      s_was_rst = reset;
      if (reset) begin
         foreach (m_pend[i]) m_pend[i] = 0;
         m_lsu_tie = 1; m_wen = 0; m_waddr = '0; m_wdata = '0;
      end else begin
         if (ga || gl) begin
            rd = gl ? bus.lsu_rd : bus.alu_rd;
            dt = gl ? bus.lsu_data : bus.alu_data;
            m_waddr = rd; m_wdata = dt; m_wen = (rd != 0);
            if (rd != 0) begin m_pend[rd] = 0; m_rf[rd] = dt; end
            m_lsu_tie = ga;
         end else begin
            m_wen = 0;
         end
         if (bus.claim_valid && bus.claim_rd != 0) m_pend[bus.claim_rd] = 1;
      end
      #1;
      chk("wr_enable", bus.wr_enable, m_wen);
      chk("wr_address", bus.wr_address, m_waddr);
      chk("wr_data", bus.wr_data, m_wdata);
      chk("pending", bus.pending, m_pend_vec());
   endtask

   task automatic chk_mem();
      @(negedge clk); #1;
      for (int i = 0; i < 32; i++) chk($sformatf("mem[%0d]", i), rd_mem(i), m_rf[i]);
   endtask

   task automatic idle_inputs();
      bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;
      bus.claim_valid = 0; bus.claim_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
   endtask

   initial begin
      foreach (m_rf[i]) m_rf[i] = 32'h0;
      foreach (m_pend[i]) m_pend[i] = 0;
      idle_inputs();
      reset = 1;
      @(posedge clk); #1;
      step();
      chk("rst_pending", bus.pending, 0);
      chk("rst_wr_enable", bus.wr_enable, 0);
      chk("rst_alu_ready", s_alu_rdy, 0);
      chk_mem();
      chk("rst_x0", rd_mem(0), 0);
      chk("rst_xA", rd_mem(10), 0);
      reset = 0;

      // ALU alone
      bus.alu_valid = 1; bus.alu_rd = 5'd10; bus.alu_data = 32'hABCDEFAB;
      step();
      chk("t1_alu_ready", s_alu_rdy, 1);
      chk("t1_wr_enable", bus.wr_enable, 1);
      chk_mem();
      chk("t1_xA", rd_mem(10), 32'hABCDEFAB);
      bus.alu_valid = 0;
      step();
      chk("t1_wr_enable_drop", bus.wr_enable, 0);

      // tie: LSU first (ALU granted last), then ALU
      bus.alu_valid = 1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
      bus.lsu_valid = 1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'h22;
      step();
      chk("t2_lsu_first", {s_alu_rdy, s_lsu_rdy}, 2'b01);
      chk("t2_addr1", bus.wr_address, 2);
      bus.lsu_valid = 0;
      step();
      chk("t2_alu_second", {s_alu_rdy, s_lsu_rdy}, 2'b10);
      bus.alu_valid = 0;
      step();
      chk_mem();
      chk("t2_x1", rd_mem(1), 32'h11);
      chk("t2_x2", rd_mem(2), 32'h22);

      // scoreboard
      bus.claim_valid = 1; bus.claim_rd = 5'd5;
      step();
      bus.claim_valid = 0; bus.rs1 = 5'd5;
      bus.lsu_valid = 1; bus.lsu_rd = 5'd5; bus.lsu_data = 32'h55;
      step();
      chk("t3_stall_set", s_stall, 1);
      bus.lsu_valid = 0;
      step();
      chk("t3_stall_clr", s_stall, 0);
      bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
      bus.claim_valid = 1; bus.claim_rd = 5'd7;
      step();
      chk("t3_set_wins", bus.pending, 32'h0000_0080);
      bus.alu_valid = 0; bus.claim_valid = 0;

      // x0 write and x0 claim
      bus.lsu_valid = 1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hEEEEEEEE;
      bus.claim_valid = 1; bus.claim_rd = 5'd0;
      step();
      chk("t4_lsu_ready", s_lsu_rdy, 1);
      chk("t4_wr_enable", bus.wr_enable, 0);
      chk("t4_pend0", bus.pending, 32'h0000_0080);
      bus.lsu_valid = 0; bus.claim_valid = 0;
      chk_mem();
      chk("t4_x0", rd_mem(0), 0);

      // reset mid-request
      bus.claim_valid = 1; bus.claim_rd = 5'd3;
      step();
      chk("t5_claim3", bus.pending, 32'h0000_0088);
      bus.claim_valid = 0;
      bus.alu_valid = 1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
      reset = 1;
      step();
      chk("t5_rst_ready", s_alu_rdy, 0);
      chk("t5_rst_pending", bus.pending, 0);
      chk("t5_rst_wen", bus.wr_enable, 0);
      reset = 0;
      step();
      chk("t5_regrant", s_alu_rdy, 1);
      bus.alu_valid = 0;
      chk_mem();
      chk("t5_x9", rd_mem(9), 32'h99);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int r;
         if (!bus.alu_valid || s_alu_rdy || s_was_rst) begin
            bus.alu_valid = ($urandom_range(0, 2) != 0);
            bus.alu_rd = 5'($urandom); bus.alu_data = $urandom;
         end
         if (!bus.lsu_valid || s_lsu_rdy || s_was_rst) begin
            bus.lsu_valid = ($urandom_range(0, 2) != 0);
            bus.lsu_rd = 5'($urandom); bus.lsu_data = $urandom;
         end
         r = $urandom_range(0, 31);
         bus.claim_rd = 5'(r);
         bus.claim_valid = ($urandom_range(0, 3) == 0) && !m_pend[r];
         bus.rs1 = 5'($urandom); bus.rs2 = 5'($urandom);
         reset = ($urandom_range(0, 99) == 0);
         step();
         if (c % 100 == 99) begin
            reset = 0; idle_inputs();
            chk_mem();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
